// File: rtl/cu_sequencer_if.sv
// Instruction memory fetch port shared by the sequencer and the memory model.
// master: drives imem_req/imem_addr, receives imem_ack/imem_rdata.
// slave:  receives imem_req/imem_addr, drives imem_ack/imem_rdata.
interface cu_sequencer_if #(
    parameter int PC_W = 64
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/cu_sequencer.sv
// ULM instruction-cycle controller: fetch, decode pulse, execute wait,
// PC advance (sequential or relative jump) and halt parking.
// Ports: clk, rst (sync, active-low); imem (fetch port, master side);
//   ir/dec_en to the decoder; cu_halt/cu_jmp/jmp_offset/exit_code_in,
//   bus_pending/bus_done/io_busy from the decoder and units;
//   pc, halted, exit_code status outputs.
// Optional build macro CU_SEQ_RETIRE_COUNT_EN adds retired[63:0] and
//   retire_pulse (instruction retirement counter).
module cu_sequencer #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    cu_sequencer_if.master    imem,
    output logic [31:0]       ir,
    output logic              dec_en,
    input  logic              cu_halt,
    input  logic              cu_jmp,
    input  logic [23:0]       jmp_offset,
    input  logic [7:0]        exit_code_in,
    input  logic              bus_pending,
    input  logic              bus_done,
    input  logic              io_busy,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
`ifdef CU_SEQ_RETIRE_COUNT_EN
    output logic [63:0]       retired,
    output logic              retire_pulse,
`endif
    output logic [7:0]        exit_code
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_ADVANCE,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            halted_q, halted_d;
    logic [7:0]      exit_code_q, exit_code_d;
    logic            done_seen_q, done_seen_d;

    logic            req;
    logic            dec;
    logic            retire;
    logic            done_now;
    logic [PC_W-1:0] jmp_ext;
    logic [PC_W-1:0] jmp_delta;

    // Offset counts instruction words; sign-extend then scale to bytes.
    assign jmp_ext   = PC_W'($signed(jmp_offset));
    assign jmp_delta = jmp_ext << 2;

    // A completion pulse in the current cycle counts as seen.
    assign done_now = done_seen_q | bus_done;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        halted_d    = halted_q;
        exit_code_d = exit_code_q;
        done_seen_d = done_seen_q;
        req         = 1'b0;
        dec         = 1'b0;
        retire      = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dec     = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cu_halt) begin
                    exit_code_d = exit_code_in;
                    halted_d    = 1'b1;
                    retire      = 1'b1;
                    state_d     = S_HALT;
                end else if ((bus_pending && !bus_done) || io_busy) begin
                    done_seen_d = done_now;
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_ADVANCE;
                end
            end
            S_WAIT: begin
                done_seen_d = done_now;
                if (!((bus_pending && !done_now) || io_busy)) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (cu_jmp) begin
                    pc_d = pc_q + jmp_delta;
                end else begin
                    pc_d = pc_q + PC_W'(4);
                end
                done_seen_d = 1'b0;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            halted_q    <= 1'b0;
            exit_code_q <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            halted_q    <= halted_d;
            exit_code_q <= exit_code_d;
            done_seen_q <= done_seen_d;
        end
    end

`ifdef CU_SEQ_RETIRE_COUNT_EN
    logic [63:0] retired_q, retired_d;
    logic        retire_pulse_q;

    assign retired_d = retire ? retired_q + 64'd1 : retired_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q      <= '0;
            retire_pulse_q <= 1'b0;
        end else begin
            retired_q      <= retired_d;
            retire_pulse_q <= retire;
        end
    end

    assign retired      = retired_q;
    assign retire_pulse = retire_pulse_q;
`endif

    // Strobes are gated by rst so they stay low in the reset cycle
    // regardless of the state left over from before reset.
    assign imem.imem_req  = req & rst;
    assign imem.imem_addr = pc_q;
    assign dec_en         = dec & rst;
    assign ir             = ir_q;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign exit_code      = exit_code_q;

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
Instruction-cycle controller for the ULM core. Fetches 32-bit instruction words from instruction memory into the instruction register and pulses the decoder enable. It then holds in execute until bus and IO operations complete, updates the PC (sequential or relative jump) and parks the core on halt. It sits between the instruction memory port and the decoder, and consumes the decoder's registered cu/bus/io outputs.

Parameters:
PC_W, 64, width of program counter and fetch address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets)
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  PC_W  fetch byte address (= pc)
imem_ack  input  1  one-cycle pulse, imem_rdata valid in same cycle
imem_rdata  input  32  fetched instruction word
ir  output  32  instruction register, drives decoder ir
dec_en  output  1  decoder enable, one-cycle pulse per instruction
cu_halt  input  1  decoded op is CU_HALT_IMM or CU_HALT_REG
cu_jmp  input  1  decoded op is CU_REL_JMP
jmp_offset  input  24  signed jump offset in instruction words
exit_code_in  input  8  resolved exit code (imm or register) for halt
bus_pending  input  1  decoded bus op != BUS_NOP
bus_done  input  1  bus unit completion pulse
io_busy  input  1  IO unit not ready (putc in progress)
pc  output  PC_W  current program counter
halted  output  1  core halted
exit_code  output  8  latched exit code

Behaviour:
- States: FETCH, DECODE, EXEC, WAIT, ADVANCE, HALT. Encoding is free.
- Reset (rst==0 at posedge): state=FETCH, pc=RESET_PC, ir=0, halted=0, exit_code=0. imem_req and dec_en are 0 during the reset cycle. Reset overrides all states, including HALT and mid-fetch; an outstanding ack arriving the cycle after reset is ignored unless the new FETCH has begun asserting imem_req.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir<=imem_rdata, go to DECODE. With no ack, stay; there is no timeout.
- DECODE: dec_en=1 for exactly this cycle; go to EXEC. Decoder outputs are valid from EXEC onward.
- EXEC, checked in priority order:
  - cu_halt: exit_code<=exit_code_in, halted<=1, go to HALT.
  - (bus_pending && !bus_done) || io_busy: go to WAIT.
  - otherwise: go to ADVANCE.
  - A bus_done in the EXEC cycle itself counts as completion.
- WAIT: stay while (bus_pending && !bus_done_seen) || io_busy.
  - bus_done_seen is a sticky flag, set by bus_done in EXEC or WAIT and cleared on entering FETCH.
  - Once both conditions clear, go to ADVANCE.
- ADVANCE:
  - If cu_jmp: pc <= pc + (sign_extend(jmp_offset) << 2). Arithmetic is modulo 2^PC_W; wrap-around is silent.
  - Otherwise: pc <= pc + 4, wrapping at 2^PC_W.
  - Go to FETCH.
  - A jump with offset 0 refetches the same address, which is a legal infinite loop.
- HALT: terminal state. imem_req=0, dec_en=0, pc frozen, halted=1. Only reset leaves HALT.
- Minimum instruction latency is 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, ADVANCE).
- imem_req is deasserted in every state except FETCH. dec_en is deasserted in every state except DECODE.
- cu_halt and cu_jmp asserted together: halt wins.

Optional Feature:
- Macro: CU_SEQ_RETIRE_COUNT_EN.
- When defined, two extra ports are added:
  - retired (output, 64): counts instructions. Resets to 0 and increments by 1 on each ADVANCE→FETCH transition and on EXEC→HALT.
  - retire_pulse (output, 1): high for one cycle at each of those events.
- Counter wraps modulo 2^64.
- When undefined, neither port nor the counter logic exists, and the remaining behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, ack same cycle, word 0x31410000 (putc 'A') with io_busy=0 -> dec_en one pulse, pc=4 after 4 cycles, imem_addr=4 in next FETCH.
- imem_ack delayed 3 cycles -> imem_req held 4 cycles with stable imem_addr, ir updates only on the ack cycle.
- EXEC with cu_jmp=1, jmp_offset=0xFFFFFE, pc=0x10 -> next imem_addr=0x08. Same test with offset 0x000003 and pc=0x10 -> 0x1C.
- bus_pending=1 with bus_done after 5 cycles, then io_busy=1 for 2 cycles in the same instruction -> stays in WAIT until both clear; pc advances exactly once.
- cu_halt=1, exit_code_in=0x2A -> halted=1, exit_code=0x2A, imem_req stays 0 for 20 cycles. rst=0 for one cycle -> pc=RESET_PC, halted=0, fetch resumes.
- rst=0 asserted mid-WAIT and again mid-FETCH -> next cycle is FETCH at RESET_PC; with CU_SEQ_RETIRE_COUNT_EN defined, retired=0 after reset and equals 3 after three completed instructions.
